// File: rtl/dp_ram_bank.sv
// -----------------------------------------------------------------------------
// dp_ram_bank
//   True dual-port synchronous RAM bank with per-byte write enables,
//   registered read data with a one-cycle read-valid strobe, and an automatic
//   zero-fill of the whole array after reset. Same-address accesses from both
//   ports in one cycle are resolved deterministically and flagged on coll.
//
//   Optional feature macro: DP_RAM_BANK_FWD_EN
//     defined   : write-first on a cross-port read/write collision. The read
//                 returns the merged post-write word and coll is not raised.
//     undefined : read-first on a cross-port read/write collision. The read
//                 returns the pre-write word and coll is raised.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width, DEPTH = 2**ADDR_W
//   BE_W    byte-enable width, derived as DATA_W/8
//
// Ports
//   clk                 single rising-edge clock
//   rst_n               synchronous active-low reset
//   en_a / en_b         port request strobe
//   we_a / we_b         1 = write, 0 = read
//   be_a / be_b         byte write enables (writes only)
//   addr_a / addr_b     word address
//   wdata_a / wdata_b   write data
//   rdata_a / rdata_b   registered read data (holds when no read is accepted)
//   rvalid_a / rvalid_b one-cycle pulse, rdata is valid
//   busy                high during reset and zero-fill; requests are ignored
//   coll                one-cycle pulse, same-address collision detected
// -----------------------------------------------------------------------------
module dp_ram_bank #(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 10,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [BE_W-1:0]   be_a,
  input  logic [BE_W-1:0]   be_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              busy,
  output logic              coll
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic              coll_q, coll_d;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  // Request qualification. rst_n is included so that a request presented on
  // the very edge that resets the bank is dropped as well.
  logic acc_a, acc_b;
  logic wr_a, wr_b, rd_a, rd_b;
  logic same_addr, ww_hit;
  logic coll_rw;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] wword_a, wword_b;

  assign acc_a     = en_a & ~busy_q & rst_n;
  assign acc_b     = en_b & ~busy_q & rst_n;
  assign wr_a      = acc_a & we_a;
  assign wr_b      = acc_b & we_b;
  assign rd_a      = acc_a & ~we_a;
  assign rd_b      = acc_b & ~we_b;
  assign same_addr = (addr_a == addr_b);
  assign ww_hit    = wr_a & wr_b & same_addr;

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  // On a write/write hit port A is layered on top of port B's merged word,
  // so A wins every byte it enables and B keeps the bytes only it enables.
  assign wword_b = byte_merge(old_b, wdata_b, be_b);
  assign wword_a = byte_merge(ww_hit ? wword_b : old_a, wdata_a, be_a);

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
`ifdef DP_RAM_BANK_FWD_EN
    // Write-first: a read hitting the other port's write sees the merged word.
    if (rd_a) rdata_a_d = (wr_b && same_addr) ? wword_b : old_a;
    if (rd_b) rdata_b_d = (wr_a && same_addr) ? wword_a : old_b;
    coll_rw = 1'b0;
`else
    // Read-first: the array is sampled before this edge's write lands.
    if (rd_a) rdata_a_d = old_a;
    if (rd_b) rdata_b_d = old_b;
    coll_rw = same_addr & ((rd_a & wr_b) | (wr_a & rd_b));
`endif
    rvalid_a_d = rd_a;
    rvalid_b_d = rd_b;
    coll_d     = (ww_hit & (|(be_a & be_b))) | coll_rw;
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    busy_d  = busy_q;
    if (state_q == ST_INIT) begin
      fill_d = fill_q + ADDR_W'(1);
      // The edge that clears the last word also releases the bank.
      if (&fill_q) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      fill_q     <= '0;
      busy_q     <= 1'b1;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      busy_q     <= busy_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      coll_q     <= coll_d;
    end
  end

  // Storage array carries no reset; it is cleared by the fill sequence.
  // When both ports hit the same word, only port A's combined word is written.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[fill_q] <= '0;
    end else begin
      if (wr_b && !ww_hit) mem[addr_b] <= wword_b;
      if (wr_a)            mem[addr_a] <= wword_a;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;
  assign coll     = coll_q;

endmodule

// File: tb/tb_dp_ram_bank.sv
// -----------------------------------------------------------------------------
// tb_dp_ram_bank
//   Directed bench for dp_ram_bank with DATA_W=16, ADDR_W=4 (16 words).
//   Covers reset state, zero-fill length, mid-fill reset, requests ignored
//   while busy, byte enables, write/write and read/write collisions,
//   read/read sharing and rvalid/rdata hold behaviour.
// -----------------------------------------------------------------------------
module tb_dp_ram_bank;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_a, en_b, we_a, we_b;
  logic [BW-1:0] be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, busy, coll;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_ram_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_a     (en_a),
    .en_b     (en_b),
    .we_a     (we_a),
    .we_b     (we_b),
    .be_a     (be_a),
    .be_b     (be_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .wdata_a  (wdata_a),
    .wdata_b  (wdata_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .busy     (busy),
    .coll     (coll)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic en, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    en_a = en; we_a = we; addr_a = ad; wdata_a = d; be_a = be;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    en_b = en; we_b = we; addr_b = ad; wdata_b = d; be_b = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int  n;
    logic saw_rv;

    // Reset state
    rst_n = 1'b0;
    idle();
    step();
    step();
    chk("rst_busy",     busy,     1);
    chk("rst_rvalid_a", rvalid_a, 0);
    chk("rst_rvalid_b", rvalid_b, 0);
    chk("rst_rdata_a",  rdata_a,  0);
    chk("rst_coll",     coll,     0);

    // First fill, with a read request held on port A throughout
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 4'h2, '0, '0);
    n = 0;
    saw_rv = 1'b0;
    do begin
      step();
      n++;
      if (rvalid_a) saw_rv = 1'b1;
    end while (busy && n < 100);
    chk("fill1_cycles", n, 16);
    chk("fill1_no_rvalid", saw_rv, 0);

    // Preload garbage everywhere
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b1, AW'(i), 16'hA5A0 + DW'(i), 2'b11);
      step();
    end
    set_a(1'b1, 1'b0, 4'hF, '0, '0);
    step();
    chk("garbage_rd", rdata_a, 16'hA5AF);

    // Reset, abort the fill at counter 9, reset again; a write to addr 0 is
    // held on port A and a read on port B the whole time
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_a(1'b1, 1'b1, 4'h0, 16'hBEEF, 2'b11);
    set_b(1'b1, 1'b0, 4'h9, '0, '0);
    for (int i = 0; i < 9; i++) step();
    chk("midfill_busy", busy, 1);
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 1);
    rst_n = 1'b1;
    n = 0;
    saw_rv = 1'b0;
    do begin
      step();
      n++;
      if (rvalid_b) saw_rv = 1'b1;
    end while (busy && n < 100);
    chk("fill2_cycles", n, 16);
    chk("fill2_no_rvalid", saw_rv, 0);

    // First accepted request right after busy drops
    idle();
    set_a(1'b1, 1'b0, 4'hF, '0, '0);
    step();
    chk("first_rd_rvalid", rvalid_a, 1);
    chk("first_rd_data",   rdata_a,  0);

    // Every word must read back as zero (addr 0 proves the busy write was dropped)
    idle();
    for (int i = 0; i < 16; i++) begin
      set_b(1'b1, 1'b0, AW'(i), '0, '0);
      step();
      chk($sformatf("zero_rd_%0d", i), {rvalid_b, rdata_b}, {1'b1, 16'h0000});
    end

    // Byte enables
    idle();
    set_a(1'b1, 1'b1, 4'h3, 16'hABCD, 2'b11);
    step();
    chk("wr_no_rvalid", rvalid_a, 0);
    set_a(1'b1, 1'b1, 4'h3, 16'h1234, 2'b01);
    step();
    idle();
    set_b(1'b1, 1'b0, 4'h3, '0, '0);
    step();
    chk("be_rdata_b",  rdata_b,  16'hAB34);
    chk("be_rvalid_b", rvalid_b, 1);
    idle();
    step();
    chk("be_rvalid_drop", rvalid_b, 0);
    chk("be_rdata_hold",  rdata_b,  16'hAB34);

    // Write/write collision, overlapping byte enables
    set_a(1'b1, 1'b1, 4'h5, 16'h1111, 2'b11);
    set_b(1'b1, 1'b1, 4'h5, 16'h2222, 2'b11);
    step();
    chk("ww_coll", coll, 1);
    idle();
    set_a(1'b1, 1'b0, 4'h5, '0, '0);
    step();
    chk("ww_coll_drop", coll, 0);
    chk("ww_data", rdata_a, 16'h1111);

    // Write/write, disjoint byte enables
    set_a(1'b1, 1'b1, 4'h5, 16'h1111, 2'b01);
    set_b(1'b1, 1'b1, 4'h5, 16'h2222, 2'b10);
    step();
    chk("ww_split_coll", coll, 0);
    idle();
    set_a(1'b1, 1'b0, 4'h5, '0, '0);
    step();
    chk("ww_split_data", rdata_a, 16'h2211);

    // Read/write collision
    set_a(1'b1, 1'b1, 4'h7, 16'h0F0F, 2'b11);
    set_b(1'b0, 1'b0, '0, '0, '0);
    step();
    set_a(1'b1, 1'b0, 4'h7, '0, '0);
    set_b(1'b1, 1'b1, 4'h7, 16'hF0F0, 2'b11);
    step();
`ifdef DP_RAM_BANK_FWD_EN
    chk("rw_rdata", rdata_a, 16'hF0F0);
    chk("rw_coll",  coll,    0);
`else
    chk("rw_rdata", rdata_a, 16'h0F0F);
    chk("rw_coll",  coll,    1);
`endif
    idle();
    set_b(1'b1, 1'b0, 4'h7, '0, '0);
    step();
    chk("rw_after", rdata_b, 16'hF0F0);

    // Read/read on the same address
    idle();
    set_a(1'b1, 1'b0, 4'h3, '0, '0);
    set_b(1'b1, 1'b0, 4'h3, '0, '0);
    step();
    chk("rr_a",    {rvalid_a, rdata_a}, {1'b1, 16'hAB34});
    chk("rr_b",    {rvalid_b, rdata_b}, {1'b1, 16'hAB34});
    chk("rr_coll", coll, 0);

    // Idle cycle after a read: single rvalid pulse, data held
    idle();
    step();
    chk("idle_rvalid_a", rvalid_a, 0);
    chk("idle_rdata_a",  rdata_a,  16'hAB34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
